imm_decode_stage: RTL

Registered, parametrised immediate-decode stage between instruction fetch and the register-read/execute stage. It classifies each instruction's immediate format, produces a sign- or zero-extended immediate at DATAWIDTH, and flags illegal encodings. Instruction and PC travel alongside through a 2-entry valid/ready skid buffer, so downstream backpressure never creates a combinational path back to fetch.

---
 rtl/imm_decode_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: classifies the immediate format and builds the extended immediate.
// Results sit in a two-entry valid/ready skid buffer, so out_ready has no combinational path to in_ready.
module imm_decode_stage #(
  parameter int DATAWIDTH    = 32,
  parameter bit ENABLE_ZICSR = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [DATAWIDTH-1:0] in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [DATAWIDTH-1:0] out_pc,
  output logic [DATAWIDTH-1:0] out_imm,
  output logic [2:0]           out_imm_type,
  output logic                 out_illegal
);

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2, IMM_B = 3'd3,
    IMM_U    = 3'd4, IMM_J = 3'd5, IMM_Z = 3'd6, IMM_SH = 3'd7
  } imm_type_e;

  typedef struct packed {
    logic [31:0]          instr;
    logic [DATAWIDTH-1:0] pc;
    logic [DATAWIDTH-1:0] imm;
    imm_type_e            imm_type;
    logic                 illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;
  logic       upper_ok_w;
  logic       upper_ok_d;

  logic [DATAWIDTH-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_z, shamt_w, shamt_d;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3[1:0] == 2'b01);
  // Shift-immediate upper bits may only encode the logical or arithmetic variant.
  assign upper_ok_w = (in_instr[31:25] == 7'b0000000) || (in_instr[31:25] == 7'b0100000);
  assign upper_ok_d = (in_instr[31:26] == 6'b000000)  || (in_instr[31:26] == 6'b010000);

  assign imm_i   = DATAWIDTH'($signed(in_instr[31:20]));
  assign imm_s   = DATAWIDTH'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b   = DATAWIDTH'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_j   = DATAWIDTH'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
  assign imm_u   = DATAWIDTH'($signed({in_instr[31:12], 12'b0}));
  assign imm_z   = DATAWIDTH'(in_instr[19:15]);
  assign shamt_w = DATAWIDTH'(in_instr[24:20]);
  assign shamt_d = DATAWIDTH'(in_instr[25:20]);

  entry_t dec;

  // NOTE: every field gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    dec.instr    = in_instr;
    dec.pc       = in_pc;
    dec.imm      = '0;
    dec.imm_type = IMM_NONE;
    dec.illegal  = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      case (opcode)
        7'b0000011, 7'b1100111: begin dec.imm_type = IMM_I; dec.imm = imm_i; end
        7'b0010011: begin
          if (!is_shift) begin
            dec.imm_type = IMM_I; dec.imm = imm_i;
          end else if (DATAWIDTH == 64 && upper_ok_d) begin
            dec.imm_type = IMM_SH; dec.imm = shamt_d;
          end else if (DATAWIDTH != 64 && upper_ok_w) begin
            dec.imm_type = IMM_SH; dec.imm = shamt_w;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        7'b0011011: begin
          if (DATAWIDTH != 64) begin
            dec.illegal = 1'b1;
          end else if (!is_shift) begin
            dec.imm_type = IMM_I; dec.imm = imm_i;
          end else if (upper_ok_w) begin
            dec.imm_type = IMM_SH; dec.imm = shamt_w;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        7'b0100011: begin dec.imm_type = IMM_S; dec.imm = imm_s; end
        7'b1100011: begin dec.imm_type = IMM_B; dec.imm = imm_b; end
        7'b1101111: begin dec.imm_type = IMM_J; dec.imm = imm_j; end
        7'b0110111, 7'b0010111: begin dec.imm_type = IMM_U; dec.imm = imm_u; end
        7'b1110011: begin
          if (ENABLE_ZICSR && funct3[2]) begin
            dec.imm_type = IMM_Z; dec.imm = imm_z;
          end
        end
        7'b0110011, 7'b0001111: ;
        7'b0111011: dec.illegal = (DATAWIDTH != 64);
        default:    dec.illegal = 1'b1;
      endcase
    end
  end

  entry_t main_q, skid_q;
  logic   main_valid, skid_valid;
  logic   accept, pop;

  assign in_ready = !skid_valid && !rst;
  assign accept   = in_valid && in_ready;
  assign pop      = main_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || pop) begin
      // Main slot is free this cycle: refill from skid first, otherwise from the input.
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) main_q <= dec;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid    = main_valid;
  assign out_instr    = main_q.instr;
  assign out_pc       = main_q.pc;
  assign out_imm      = main_q.imm;
  assign out_imm_type = main_q.imm_type;
  assign out_illegal  = main_q.illegal;

endmodule
